// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// Module  : mem_initiator
// Brief   : valid/ready memory bus master. Writes and/or reads back the
//           pattern (seed + k) over a wrapping address range and reports the
//           mismatch count and the first failing address. Per-beat stall
//           timeout is compiled in when MEM_INIT_TIMEOUT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module mem_initiator #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 16,
  parameter int ADDRESS_WIDTH  = $clog2(DEPTH),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [1:0]               mode_i,
  input  logic [ADDRESS_WIDTH-1:0] start_addr_i,
  input  logic [ADDRESS_WIDTH:0]   num_i,
  input  logic [WIDTH-1:0]         seed_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDRESS_WIDTH:0]   err_cnt_o,
  output logic [ADDRESS_WIDTH-1:0] first_err_addr_o,
  output logic                     timeout_o,
  output logic                     valid_o,
  output logic                     wr_rd_en_o,
  output logic [ADDRESS_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]         wdata_o,
  input  logic                     ready_i,
  input  logic [WIDTH-1:0]         rdata_i
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_WRITE = 3'd1;
  localparam logic [2:0] c_TURN  = 3'd2;
  localparam logic [2:0] c_READ  = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [1:0] c_MODE_RD    = 2'b01;
  localparam logic [1:0] c_MODE_WR_RD = 2'b10;

  localparam logic [ADDRESS_WIDTH:0] c_DEPTH = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0] c_ONE   = (ADDRESS_WIDTH+1)'(1);

  logic [2:0]               r_state;
  logic [2:0]               w_next_state;
  logic [1:0]               r_mode;
  logic [ADDRESS_WIDTH-1:0] r_start_addr;
  logic [ADDRESS_WIDTH:0]   r_num;
  logic [WIDTH-1:0]         r_seed;
  logic [ADDRESS_WIDTH:0]   r_beat;
  logic [ADDRESS_WIDTH:0]   r_err_cnt;
  logic [ADDRESS_WIDTH-1:0] r_first_err_addr;

  logic [ADDRESS_WIDTH:0]   w_num_sat;
  logic [ADDRESS_WIDTH:0]   w_addr_sum;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [WIDTH-1:0]         w_data;
  logic                     w_start;
  logic                     w_active;
  logic                     w_fire;
  logic                     w_last;
  logic                     w_timeout_hit;

  assign w_num_sat  = (num_i > c_DEPTH) ? c_DEPTH : num_i;
  assign w_start    = (r_state == c_IDLE) && start_i;
  assign w_active   = (r_state == c_WRITE) || (r_state == c_READ);
  assign w_fire     = w_active && ready_i;
  assign w_last     = (r_beat == (r_num - c_ONE));

  // start_addr and beat are both below DEPTH, so one conditional subtract wraps
  assign w_addr_sum = {1'b0, r_start_addr} + r_beat;
  assign w_addr     = ADDRESS_WIDTH'((w_addr_sum >= c_DEPTH) ? (w_addr_sum - c_DEPTH) : w_addr_sum);
  assign w_data     = WIDTH'({{(ADDRESS_WIDTH+1){1'b0}}, r_seed} + {{WIDTH{1'b0}}, r_beat});

`ifdef MEM_INIT_TIMEOUT_EN
  localparam int c_STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_STALL_W-1:0] c_STALL_ONE  = c_STALL_W'(1);

  logic [c_STALL_W-1:0] r_stall;
  logic                 r_timeout;

  assign w_timeout_hit = w_active && !ready_i && (r_stall == c_STALL_LAST);
  assign timeout_o     = r_timeout;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_start) begin
        r_timeout <= 1'b0;
      end else if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
      if (!w_active || w_fire) begin
        r_stall <= '0;
      end else begin
        r_stall <= r_stall + c_STALL_ONE;
      end
    end
  end
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout_hit        = 1'b0;
  assign timeout_o            = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (start_i) begin
          if (w_num_sat == '0) begin
            w_next_state = c_DONE;
          end else if (mode_i == c_MODE_RD) begin
            w_next_state = c_READ;
          end else begin
            w_next_state = c_WRITE;
          end
        end
      end
      c_WRITE: begin
        if (w_timeout_hit) begin
          w_next_state = c_DONE;
        end else if (w_fire && w_last) begin
          w_next_state = (r_mode == c_MODE_WR_RD) ? c_TURN : c_DONE;
        end
      end
      c_TURN:  w_next_state = c_READ;
      c_READ: begin
        if (w_timeout_hit || (w_fire && w_last)) begin
          w_next_state = c_DONE;
        end
      end
      c_DONE:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    valid_o    = w_active;
    wr_rd_en_o = (r_state == c_WRITE);
    busy_o     = w_active || (r_state == c_TURN);
    done_o     = (r_state == c_DONE);
    addr_o     = '0;
    wdata_o    = '0;
    if (w_active) begin
      addr_o = w_addr;
    end
    if (r_state == c_WRITE) begin
      wdata_o = w_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mode       <= '0;
      r_start_addr <= '0;
      r_num        <= '0;
      r_seed       <= '0;
      r_beat       <= '0;
    end else begin
      if (w_start) begin
        r_mode       <= mode_i;
        r_start_addr <= start_addr_i;
        r_num        <= w_num_sat;
        r_seed       <= seed_i;
        r_beat       <= '0;
      end else if (r_state == c_TURN) begin
        r_beat <= '0;
      end else if (w_fire) begin
        r_beat <= r_beat + c_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else if (w_start) begin
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else if (w_fire && (r_state == c_READ) && (rdata_i != w_data)) begin
      if (r_err_cnt == '0) begin
        r_first_err_addr <= w_addr;
      end
      if (!(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + c_ONE;
      end
    end
  end

  assign err_cnt_o        = r_err_cnt;
  assign first_err_addr_o = r_first_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// Bench for mem_initiator: directed and randomized commands against a
// behavioural memory and pattern model.
module tb_mem_initiator;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [1:0] mode_i;
  logic [3:0] start_addr_i;
  logic [4:0] num_i;
  logic [7:0] seed_i;
  logic       busy_o, done_o, timeout_o, valid_o, wr_rd_en_o;
  logic [4:0] err_cnt_o;
  logic [3:0] first_err_addr_o, addr_o;
  logic [7:0] wdata_o;
  logic       ready_i;
  logic [7:0] rdata_i;

  logic [7:0] mem [D];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_initiator dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .start_addr_i(start_addr_i), .num_i(num_i), .seed_i(seed_i),
    .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o), .timeout_o(timeout_o),
    .valid_o(valid_o), .wr_rd_en_o(wr_rd_en_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .ready_i(ready_i), .rdata_i(rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One command from start strobe to done; called at a falling edge.
  task automatic run_cmd(input logic [1:0] mode, input int start, input int num, input int seed,
                         input int ready_pct, input int stall_beat, input int stall_len,
                         input int corrupt_pct);
    int n, wc, rc, fired, gap, since_fire, streak, stall_left, exp_err, exp_first, a, d;
    bit has_w, has_r, got_done, wphase, rdy, prev_stall;
    logic [3:0] p_addr;
    logic [7:0] p_wdata, rd;
    logic       p_wr;
    n = (num > D) ? D : num;
    has_w = (mode != 2'b01);
    has_r = (mode == 2'b01) || (mode == 2'b10);
    wc = 0; rc = 0; fired = 0; gap = 0; since_fire = -1; streak = 0;
    stall_left = stall_len; exp_err = 0; exp_first = 0;
    prev_stall = 0; got_done = 0; p_addr = '0; p_wdata = '0; p_wr = 1'b0;
    start_i = 1'b1; mode_i = mode; start_addr_i = 4'(start); num_i = 5'(num); seed_i = 8'(seed);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    mode_i = 2'($urandom); start_addr_i = 4'($urandom); num_i = 5'($urandom); seed_i = 8'($urandom);
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      if (cyc == 0) begin
        if (n > 0) chk("first_beat_valid", valid_o, 1);
        else begin
          chk("zero_num_done", done_o, 1);
          chk("zero_num_valid", valid_o, 0);
        end
      end
      if (prev_stall) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_addr", addr_o, p_addr);
        chk("hold_wdata", wdata_o, p_wdata);
        chk("hold_wr", wr_rd_en_o, p_wr);
      end
      if (done_o) begin
        got_done = 1;
        if (n > 0) chk("done_latency", since_fire, 1);
        chk("done_busy", busy_o, 0);
        chk("done_valid", valid_o, 0);
        chk("write_beats", wc, has_w ? n : 0);
        chk("read_beats", rc, has_r ? n : 0);
        if (mode == 2'b10 && n > 0) chk("turn_gap", gap, 1);
        chk("err_cnt", err_cnt_o, exp_err);
        chk("first_err_addr", first_err_addr_o, exp_first);
        chk("timeout_clear", timeout_o, 0);
        // start during DONE must be ignored
        start_i = 1'b1; mode_i = 2'b00; num_i = 5'd3;
      end else if (valid_o) begin
        chk("busy_active", busy_o, 1);
        wphase = has_w && (wc < n);
        if (fired == stall_beat && stall_left > 0) begin
          rdy = 0;
          stall_left--;
        end else if (streak >= 4) rdy = 1;
        else rdy = ($urandom_range(99) < ready_pct);
        ready_i = rdy;
        rd = mem[addr_o];
        if (!wphase && $urandom_range(99) < corrupt_pct) rd = rd ^ 8'($urandom_range(255, 1));
        rdata_i = rd;
        if (wphase) begin
          a = (start + wc) % D; d = (seed + wc) % 256;
          chk("wr_flag", wr_rd_en_o, 1);
          chk("wr_addr", addr_o, a);
          chk("wr_data", wdata_o, d);
        end else begin
          a = (start + rc) % D; d = (seed + rc) % 256;
          chk("rd_flag", wr_rd_en_o, 0);
          chk("rd_addr", addr_o, a);
          chk("rd_wdata_zero", wdata_o, 0);
        end
        if (rdy) begin
          if (wphase) begin
            mem[a] = 8'(d);
            wc++;
          end else begin
            if (rd != 8'(d)) begin
              if (exp_err == 0) exp_first = a;
              exp_err++;
            end
            rc++;
          end
          fired++; since_fire = 0; streak = 0;
        end else streak++;
        prev_stall = !rdy; p_addr = addr_o; p_wdata = wdata_o; p_wr = wr_rd_en_o;
      end else begin
        chk("idle_wdata", wdata_o, 0);
        ready_i = 1'($urandom_range(1));
        if (has_r && has_w && wc == n && rc == 0) begin
          gap++;
          chk("turn_busy", busy_o, 1);
        end
        prev_stall = 0;
      end
      if (since_fire >= 0) since_fire++;
      @(negedge clk);
    end
    if (!got_done) chk("done_seen", 0, 1);
    start_i = 1'b0;
    chk("done_one_pulse", done_o, 0);
    chk("start_in_done_ignored", valid_o, 0);
    chk("idle_busy", busy_o, 0);
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; mode_i = '0; start_addr_i = '0; num_i = '0; seed_i = '0;
    ready_i = 1'b0; rdata_i = '0;
    for (int i = 0; i < D; i++) mem[i] = 8'h00;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_cnt_o, 0);
    chk("rst_first", first_err_addr_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    @(negedge clk); @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);

    run_cmd(2'b00, 2, 4, 'h10, 100, -1, 0, 0);
    run_cmd(2'b10, 14, 4, 'hA0, 100, -1, 0, 0);

    for (int i = 0; i < D; i++) mem[i] = 8'(i);
    mem[3] = 8'hFF;
    run_cmd(2'b01, 0, 16, 0, 100, -1, 0, 0);
    chk("mismatch_cnt", err_cnt_o, 1);
    chk("mismatch_addr", first_err_addr_o, 3);

    run_cmd(2'b00, 5, 6, 'h33, 100, 1, 3, 0);
    run_cmd(2'b00, 7, 0, 'h01, 100, -1, 0, 0);
    run_cmd(2'b11, 3, 31, 'h80, 100, -1, 0, 0);
    run_cmd(2'b10, 9, 7, 'hFE, 100, -1, 0, 60);

    // asynchronous reset in the middle of a write burst
    start_i = 1'b1; mode_i = 2'b00; start_addr_i = 4'd0; num_i = 5'd8; seed_i = 8'h40; ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    start_i = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_mid_pre_addr", addr_o, 2);
    chk("rst_mid_pre_valid", valid_o, 1);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_mid_valid", valid_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_wdata", wdata_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_done", done_o, 0);
    end
    rst_i = 1'b1;
    @(negedge clk);
    run_cmd(2'b10, 4, 5, 'h21, 100, -1, 0, 0);

    for (int t = 0; t < 24; t++) begin
      run_cmd(2'($urandom_range(3)), $urandom_range(15), $urandom_range(31), $urandom_range(255),
              $urandom_range(100, 40), -1, 0, $urandom_range(30));
    end

`ifdef MEM_INIT_TIMEOUT_EN
    begin
      int vcnt;
      bit dropped;
      vcnt = 0; dropped = 0;
      start_i = 1'b1; mode_i = 2'b00; start_addr_i = 4'd1; num_i = 5'd4; seed_i = 8'h00; ready_i = 1'b0;
      @(posedge clk); @(negedge clk);
      start_i = 1'b0;
      for (int c = 0; c < 100 && !dropped; c++) begin
        if (valid_o) begin
          vcnt++;
          @(negedge clk);
        end else dropped = 1;
      end
      chk("to_stall_cycles", vcnt, 16);
      chk("to_done", done_o, 1);
      chk("to_flag", timeout_o, 1);
      @(negedge clk);
      chk("to_done_once", done_o, 0);
      chk("to_sticky", timeout_o, 1);
      chk("to_valid_low", valid_o, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Bus master for the valid/ready single-port memory interface used across this project. It is the initiator end that drives the memory block.
- On a start command it writes a deterministic data pattern over a contiguous, wrapping address range, reads the range back, or does both.
- Read data is compared against the expected pattern. The block reports an error count and the address of the first mismatch.
- Intended use: self-test engine and traffic generator in front of memory_design-style targets.

Parameters:
- WIDTH, 8, data width in bits
- DEPTH, 16, number of addressable locations
- ADDRESS_WIDTH, $clog2(DEPTH), address width in bits
- TIMEOUT_CYCLES, 16, stall limit per beat; used only when MEM_INIT_TIMEOUT_EN is defined

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  asynchronous, active-low reset
- start_i  input  1  command strobe, sampled only in IDLE
- mode_i  input  2  00 = write only, 01 = read/check only, 10 = write then read/check, 11 = reserved (treated as 00)
- start_addr_i  input  ADDRESS_WIDTH  first address
- num_i  input  ADDRESS_WIDTH+1  number of locations; saturates to DEPTH
- seed_i  input  WIDTH  pattern seed
- busy_o  output  1  command in progress
- done_o  output  1  one-cycle completion pulse
- err_cnt_o  output  ADDRESS_WIDTH+1  read mismatches; saturating
- first_err_addr_o  output  ADDRESS_WIDTH  address of first mismatch
- timeout_o  output  1  sticky abort flag; constant 0 without the macro
- valid_o  output  1  request valid to memory
- wr_rd_en_o  output  1  1 = write, 0 = read
- addr_o  output  ADDRESS_WIDTH  request address
- wdata_o  output  WIDTH  write data
- ready_i  input  1  memory accepts request; for reads, rdata_i is valid in the same cycle
- rdata_i  input  WIDTH  read data

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - All outputs go to 0 immediately; FSM goes to IDLE.
  - Asserting reset mid-transfer drops valid_o with no completion and no done_o pulse.
- FSM states: IDLE, WRITE, TURN, READ, DONE.
- IDLE:
  - busy_o = 0, valid_o = 0.
  - On start_i at a rising edge: latch all command inputs, clear err_cnt_o, first_err_addr_o and timeout_o, set busy_o.
  - If the saturated count is 0, go to DONE.
  - Otherwise go to WRITE (modes 00, 10, 11) or READ (mode 01).
- Addressing and pattern:
  - Beat k, for k = 0..N-1, uses address addr_k = (start_addr + k) mod DEPTH, so the range wraps from DEPTH-1 to 0.
  - Expected and write data for beat k: data_k = (seed + k) mod 2^WIDTH.
- WRITE / READ:
  - valid_o = 1 and wr_rd_en_o = 1 in WRITE, 0 in READ.
  - The first beat appears the cycle after start_i.
  - A beat completes on a rising edge where valid_o && ready_i.
  - While ready_i = 0, valid_o, addr_o, wdata_o and wr_rd_en_o are held stable.
  - After a completed beat, the next beat's address and data appear the following cycle. valid_o stays high, so throughput is 1 beat per cycle when ready_i = 1.
  - READ compare: at the completing edge, rdata_i is compared with data_k.
    - On mismatch, err_cnt_o increments, saturating at all-ones.
    - On the first mismatch, first_err_addr_o = addr_k.
  - After the final beat: from WRITE go to TURN for mode 10, otherwise to DONE; from READ go to DONE.
- TURN: one cycle with valid_o = 0, beat counter reset, then go to READ.
- DONE: done_o = 1 for one cycle, busy_o = 0, then go to IDLE.
- start_i while busy_o = 1 is ignored.
- start_i in the DONE cycle is ignored; start_i is accepted from the next cycle onward.
- wdata_o = 0 whenever valid_o = 0 or wr_rd_en_o = 0.

Optional Feature:
- Macro MEM_INIT_TIMEOUT_EN.
- Defined:
  - A per-beat stall counter counts consecutive cycles with valid_o = 1 and ready_i = 0.
  - When it reaches TIMEOUT_CYCLES: valid_o drops the next cycle, timeout_o is set (sticky until next start), and the FSM goes to DONE (done_o pulses).
  - Counter resets on every completed beat.
- Not defined: no counter; timeout_o tied to 0; the initiator waits for ready_i indefinitely.

Test Plan:
- Write-only: mode 00, start 2, num 4, seed 0x10, ready_i = 1 → valid_o high 4 cycles, addr 2,3,4,5, wdata 0x10..0x13, done_o the cycle after the last beat, err_cnt_o = 0.
- Wrap: mode 10, start 14, num 4, seed 0xA0, memory model → writes to 14,15,0,1 with 0xA0..0xA3; one TURN cycle with valid_o = 0; reads to 14,15,0,1; err_cnt_o = 0.
- Mismatch: mode 01, start 0, num 16, seed 0, memory preloaded with addr values except mem[3] = 0xFF → err_cnt_o = 1, first_err_addr_o = 3.
- Stall: ready_i low 3 cycles on beat 1 → addr_o and wdata_o held 4 cycles, no duplicate or skipped beat. num_i = 0 → done_o the cycle after start, valid_o never high. num_i = 31 → exactly 16 beats.
- Reset mid-write at beat 2 → valid_o and busy_o go 0 without a clock edge, no done_o; a new start then runs normally.
- With MEM_INIT_TIMEOUT_EN, ready_i held 0 → valid_o drops after 16 stall cycles, timeout_o = 1, done_o pulses once.
